alu_dispatch: RTL and testbench

//  Issue stage between decode and the ALU. Accepts one ALU op per valid/ready handshake.

---
 rtl/alu_dispatch.sv | 198 +++++++++++++++++++
 tb/tb_alu_dispatch.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// alu_dispatch: issue stage between decode and the ALU.
// Single-cycle ops go straight to the ALU combinational path and are written
// back one cycle later. SRL/SLL/MUL launch the ALU sequential path, with the
// operands held stable until the ALU reports idle. Zero-distance shifts bypass
// the ALU entirely. Every result leaves through a one-entry writeback buffer.
module alu_dispatch #(
    parameter int                      OPERAND_WIDTH  = 64,
    parameter int                      OPCODE_WIDTH   = 4,
    parameter int                      RD_WIDTH       = 5,
    parameter logic [OPCODE_WIDTH-1:0] SRL_OP         = 'd6,
    parameter logic [OPCODE_WIDTH-1:0] SLL_OP         = 'd5,
    parameter logic [OPCODE_WIDTH-1:0] MUL_OP         = 'd7,
    parameter int                      TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCODE_WIDTH-1:0]  in_opcode,
    input  logic [OPERAND_WIDTH-1:0] in_op1,
    input  logic [OPERAND_WIDTH-1:0] in_op2,
    input  logic [RD_WIDTH-1:0]      in_rd,
    input  logic                     flush,
    output logic [OPERAND_WIDTH-1:0] alu_operand_1,
    output logic [OPERAND_WIDTH-1:0] alu_operand_2,
    output logic [OPCODE_WIDTH-1:0]  alu_op_code,
    output logic                     alu_enable_comb,
    output logic                     alu_enable_seq,
    input  logic                     alu_idle,
    input  logic [OPERAND_WIDTH-1:0] alu_res_1cycle,
    input  logic [OPERAND_WIDTH-1:0] alu_res_multi,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [RD_WIDTH-1:0]      wb_rd,
    output logic [OPERAND_WIDTH-1:0] wb_data,
    output logic                     err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, SEQ_START, SEQ_WAIT} state_t;

    state_t                   state;
    state_t                   state_nxt;

    logic [OPERAND_WIDTH-1:0] hold_op1;
    logic [OPERAND_WIDTH-1:0] hold_op2;
    logic [OPCODE_WIDTH-1:0]  hold_opcode;
    logic [RD_WIDTH-1:0]      hold_rd;
    logic [CNT_W-1:0]         cnt;
    logic                     drop;

    logic                     slot_free;
    logic                     is_shift;
    logic                     is_bypass;
    logic                     is_seq_op;
    logic                     accept;
    logic                     timeout_hit;
    logic                     seq_capture;
    logic                     comb_capture;
    logic                     bypass_capture;

    assign slot_free      = !wb_valid || wb_ready;
    assign is_shift       = (in_opcode == SRL_OP) || (in_opcode == SLL_OP);
    assign is_bypass      = is_shift && (in_op2 == '0);
    assign is_seq_op      = (is_shift && (in_op2 != '0)) || (in_opcode == MUL_OP);
    assign accept         = in_valid && in_ready;
    assign comb_capture   = accept && !is_seq_op && !is_bypass;
    assign bypass_capture = accept && is_bypass;
    // Watchdog fires only while the ALU is still busy; an idle ALU is handled normally.
    assign timeout_hit    = (state == SEQ_WAIT) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !alu_idle;
    // A flushed or dropped run completes in the ALU but its result never enters the buffer.
    assign seq_capture    = (state == SEQ_WAIT) && alu_idle && slot_free && !drop && !flush;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && is_seq_op) begin
                    state_nxt = SEQ_START;
                end
            end
            SEQ_START: begin
                state_nxt = SEQ_WAIT;
            end
            SEQ_WAIT: begin
                if (timeout_hit) begin
                    state_nxt = IDLE;
                end else if (alu_idle && (drop || flush || slot_free)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic: handshake, ALU drive and enables
    always_comb begin
        in_ready        = 1'b0;
        alu_operand_1   = '0;
        alu_operand_2   = '0;
        alu_op_code     = '0;
        alu_enable_comb = 1'b0;
        alu_enable_seq  = 1'b0;
        case (state)
            IDLE: begin
                // Gating with rst_n keeps every output at 0 while reset is held.
                in_ready = rst_n && slot_free && alu_idle && !flush;
                if (in_valid && in_ready) begin
                    alu_operand_1   = in_op1;
                    alu_operand_2   = in_op2;
                    alu_op_code     = in_opcode;
                    alu_enable_comb = !is_seq_op && !is_bypass;
                    alu_enable_seq  = is_seq_op;
                end
            end
            SEQ_START, SEQ_WAIT: begin
                // The ALU re-reads operand_2 every shift cycle, so keep it steady.
                alu_operand_1 = hold_op1;
                alu_operand_2 = hold_op2;
                alu_op_code   = hold_opcode;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Latch operands of a sequential op for the whole ALU run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_op1    <= '0;
            hold_op2    <= '0;
            hold_opcode <= '0;
            hold_rd     <= '0;
        end else if (accept && is_seq_op) begin
            hold_op1    <= in_op1;
            hold_op2    <= in_op2;
            hold_opcode <= in_opcode;
            hold_rd     <= in_rd;
        end
    end

    // Watchdog counter, drop flag and sticky timeout error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            drop        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (state == SEQ_START) begin
                cnt <= '0;
            end else if (state == SEQ_WAIT) begin
                cnt <= cnt + 1'b1;
            end
            drop        <= (state != IDLE) ? (drop || flush) : 1'b0;
            err_timeout <= err_timeout || timeout_hit;
        end
    end

    // One-entry writeback buffer; a new capture wins over a same-cycle handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            if (comb_capture) begin
                wb_valid <= 1'b1;
                wb_rd    <= in_rd;
                wb_data  <= alu_res_1cycle;
            end else if (bypass_capture) begin
                wb_valid <= 1'b1;
                wb_rd    <= in_rd;
                wb_data  <= in_op1;
            end else if (seq_capture) begin
                wb_valid <= 1'b1;
                wb_rd    <= hold_rd;
                wb_data  <= alu_res_multi;
            end else if (flush || wb_ready) begin
                wb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: directed bench for alu_dispatch with a small behavioural
// ALU (combinational ADD/shift/MUL path plus a sequential path whose latency
// the stimulus sets per step). The sequential result is computed from the
// operands present when the ALU finishes, so unstable operands show up in data.
module tb_alu_dispatch;

    localparam int W  = 64;
    localparam int OW = 4;
    localparam int RW = 5;
    localparam int TO = 16;

    localparam logic [OW-1:0] OP_ADD = 4'd0;
    localparam logic [OW-1:0] OP_SLL = 4'd5;
    localparam logic [OW-1:0] OP_SRL = 4'd6;
    localparam logic [OW-1:0] OP_MUL = 4'd7;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] in_opcode;
    logic [W-1:0]  in_op1;
    logic [W-1:0]  in_op2;
    logic [RW-1:0] in_rd;
    logic          flush;
    logic [W-1:0]  alu_operand_1;
    logic [W-1:0]  alu_operand_2;
    logic [OW-1:0] alu_op_code;
    logic          alu_enable_comb;
    logic          alu_enable_seq;
    logic          alu_idle;
    logic [W-1:0]  alu_res_1cycle;
    logic [W-1:0]  alu_res_multi;
    logic          wb_valid;
    logic          wb_ready;
    logic [RW-1:0] wb_rd;
    logic [W-1:0]  wb_data;
    logic          err_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int lat   = 4;
    int n_comb_en = 0;
    int n_seq_en  = 0;
    int n_both_en = 0;

    logic busy;
    int   busy_cnt;

    alu_dispatch #(
        .OPERAND_WIDTH (W),
        .OPCODE_WIDTH  (OW),
        .RD_WIDTH      (RW),
        .SRL_OP        (OP_SRL),
        .SLL_OP        (OP_SLL),
        .MUL_OP        (OP_MUL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_opcode      (in_opcode),
        .in_op1         (in_op1),
        .in_op2         (in_op2),
        .in_rd          (in_rd),
        .flush          (flush),
        .alu_operand_1  (alu_operand_1),
        .alu_operand_2  (alu_operand_2),
        .alu_op_code    (alu_op_code),
        .alu_enable_comb(alu_enable_comb),
        .alu_enable_seq (alu_enable_seq),
        .alu_idle       (alu_idle),
        .alu_res_1cycle (alu_res_1cycle),
        .alu_res_multi  (alu_res_multi),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .err_timeout    (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_fn(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SLL:  return a << b[5:0];
            OP_SRL:  return a >> b[5:0];
            OP_MUL:  return a * b;
            default: return '0;
        endcase
    endfunction

    // Behavioural ALU
    assign alu_res_1cycle = alu_fn(alu_op_code, alu_operand_1, alu_operand_2);
    assign alu_idle       = !busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy          <= 1'b0;
            busy_cnt      <= 0;
            alu_res_multi <= '0;
        end else if (alu_enable_seq) begin
            busy     <= 1'b1;
            busy_cnt <= lat;
        end else if (busy) begin
            if (busy_cnt == 1) begin
                busy          <= 1'b0;
                alu_res_multi <= alu_fn(alu_op_code, alu_operand_1, alu_operand_2);
            end
            busy_cnt <= busy_cnt - 1;
        end
    end

    // Enable activity monitor
    always @(posedge clk) begin
        if (rst_n) begin
            if (alu_enable_comb) n_comb_en <= n_comb_en + 1;
            if (alu_enable_seq)  n_seq_en  <= n_seq_en + 1;
            if (alu_enable_comb && alu_enable_seq) n_both_en <= n_both_en + 1;
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [OW-1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [RW-1:0] rd);
        in_valid  = v;
        in_opcode = op;
        in_op1    = a;
        in_op2    = b;
        in_rd     = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=stuck expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int  cyc;
        logic ok_a;
        logic ok_b;

        rst_n    = 1'b0;
        flush    = 1'b0;
        wb_ready = 1'b1;
        drive(1'b1, OP_ADD, 64'd5, 64'd7, 5'd3);
        tick();
        tick();
        // Reset state: outputs all 0 even with an op presented
        chk("rst_in_ready", in_ready, 0);
        chk("rst_enable_comb", alu_enable_comb, 0);
        chk("rst_operand_1", alu_operand_1, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_err_timeout", err_timeout, 0);
        drive(1'b0, OP_ADD, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // ADD 5+7 -> rd 3, latency 1
        drive(1'b1, OP_ADD, 64'd5, 64'd7, 5'd3);
        #1;
        chk("add_in_ready", in_ready, 1);
        chk("add_enable_comb", alu_enable_comb, 1);
        chk("add_enable_seq", alu_enable_seq, 0);
        chk("add_operand_2", alu_operand_2, 7);
        tick();
        in_valid = 1'b0;
        chk("add_wb_valid", wb_valid, 1);
        chk("add_wb_data", wb_data, 12);
        chk("add_wb_rd", wb_rd, 3);
        tick();
        chk("add_wb_drained", wb_valid, 0);

        // MUL 6*7 -> rd 9 over the sequential path
        lat = 5;
        drive(1'b1, OP_MUL, 64'd6, 64'd7, 5'd9);
        #1;
        chk("mul_enable_seq", alu_enable_seq, 1);
        chk("mul_enable_comb", alu_enable_comb, 0);
        tick();
        drive(1'b0, OP_ADD, 64'hDEAD, 64'hBEEF, 5'd1);
        chk("mul_start_ready", in_ready, 0);
        chk("mul_start_enable_seq", alu_enable_seq, 0);
        ok_a = 1'b1;
        ok_b = 1'b1;
        cyc  = 0;
        while (!wb_valid && cyc < 40) begin
            if (alu_operand_1 !== 64'd6 || alu_operand_2 !== 64'd7 || alu_op_code !== OP_MUL) ok_a = 1'b0;
            if (in_ready !== 1'b0) ok_b = 1'b0;
            tick();
            cyc++;
        end
        chk("mul_wb_valid", wb_valid, 1);
        chk("mul_operands_stable", ok_a, 1);
        chk("mul_ready_low_during_run", ok_b, 1);
        chk("mul_wb_data", wb_data, 42);
        chk("mul_wb_rd", wb_rd, 9);
        tick();

        // SLL by zero bypasses the ALU
        drive(1'b1, OP_SLL, 64'hF0, 64'd0, 5'd4);
        #1;
        chk("bypass_in_ready", in_ready, 1);
        chk("bypass_enable_comb", alu_enable_comb, 0);
        chk("bypass_enable_seq", alu_enable_seq, 0);
        tick();
        in_valid = 1'b0;
        chk("bypass_wb_valid", wb_valid, 1);
        chk("bypass_wb_data", wb_data, 64'hF0);
        chk("bypass_wb_rd", wb_rd, 4);
        tick();

        // Back-pressure: two ADDs with wb_ready low
        wb_ready = 1'b0;
        drive(1'b1, OP_ADD, 64'd1, 64'd2, 5'd1);
        #1;
        chk("bp_first_ready", in_ready, 1);
        tick();
        drive(1'b1, OP_ADD, 64'd10, 64'd20, 5'd2);
        #1;
        chk("bp_second_blocked", in_ready, 0);
        chk("bp_blocked_enable", alu_enable_comb, 0);
        tick();
        chk("bp_hold_valid", wb_valid, 1);
        chk("bp_hold_data", wb_data, 3);
        chk("bp_hold_rd", wb_rd, 1);
        wb_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_second_valid", wb_valid, 1);
        chk("bp_second_data", wb_data, 30);
        chk("bp_second_rd", wb_rd, 2);
        tick();
        chk("bp_drained", wb_valid, 0);

        // SRL 0x100>>4 flushed mid-run
        lat = 6;
        drive(1'b1, OP_SRL, 64'h100, 64'd4, 5'd5);
        #1;
        chk("srl_enable_seq", alu_enable_seq, 1);
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ok_a = 1'b1;
        ok_b = 1'b1;
        cyc  = 0;
        while (!alu_idle && cyc < 30) begin
            if (wb_valid !== 1'b0) ok_a = 1'b0;
            if (in_ready !== 1'b0) ok_b = 1'b0;
            tick();
            cyc++;
        end
        chk("srl_alu_finished", alu_idle, 1);
        chk("srl_flush_no_wb", ok_a, 1);
        chk("srl_ready_low_while_busy", ok_b, 1);
        tick();
        chk("srl_flush_no_wb_after", wb_valid, 0);
        chk("srl_ready_back", in_ready, 1);
        drive(1'b1, OP_ADD, 64'd2, 64'd3, 5'd4);
        tick();
        in_valid = 1'b0;
        chk("post_flush_add_data", wb_data, 5);
        chk("post_flush_add_valid", wb_valid, 1);
        tick();

        // Watchdog: ALU slower than the timeout
        lat = 40;
        drive(1'b1, OP_MUL, 64'd3, 64'd3, 5'd6);
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!err_timeout && cyc < 60) begin
            tick();
            cyc++;
        end
        chk("timeout_err", err_timeout, 1);
        chk("timeout_cycles", cyc, 17);
        chk("timeout_no_wb", wb_valid, 0);
        chk("timeout_ready_low", in_ready, 0);
        ok_a = 1'b1;
        cyc  = 0;
        while (!alu_idle && cyc < 60) begin
            if (wb_valid !== 1'b0) ok_a = 1'b0;
            tick();
            cyc++;
        end
        chk("timeout_dropped", ok_a, 1);
        tick();
        chk("timeout_late_no_wb", wb_valid, 0);
        drive(1'b1, OP_ADD, 64'd8, 64'd1, 5'd8);
        tick();
        in_valid = 1'b0;
        chk("timeout_next_add", wb_data, 9);
        chk("timeout_err_sticky", err_timeout, 1);
        tick();

        // Reset in the middle of a MUL run
        lat = 8;
        drive(1'b1, OP_MUL, 64'd6, 64'd7, 5'd9);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        drive(1'b1, OP_ADD, 64'd1, 64'd1, 5'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_enable_seq", alu_enable_seq, 0);
        chk("midrst_enable_comb", alu_enable_comb, 0);
        chk("midrst_operand_1", alu_operand_1, 0);
        chk("midrst_op_code", alu_op_code, 0);
        chk("midrst_wb_valid", wb_valid, 0);
        chk("midrst_err", err_timeout, 0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_alu_idle", alu_idle, 1);
        drive(1'b1, OP_ADD, 64'd4, 64'd4, 5'd7);
        tick();
        in_valid = 1'b0;
        chk("midrst_add_valid", wb_valid, 1);
        chk("midrst_add_data", wb_data, 8);
        chk("midrst_add_rd", wb_rd, 7);
        tick();

        // Enable activity over the whole run
        chk("enables_never_both", n_both_en, 0);
        chk("seq_enable_count", n_seq_en, 4);
        chk("comb_enable_count", n_comb_en, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
